// File: rtl/shift_framer_pkg.sv
// Shared constants for the shift_framer block: shift-direction encoding and default width.
package shift_framer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic MODE_MSB_FIRST = 1'b0;
    localparam logic MODE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_framer_core.sv
// shift_core: the data register with its load/shift direction mux and serial-out tap.
// The post-edge value is exported so the framer can capture a completed frame on the same edge.
module shift_core
    import shift_framer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    input  logic             i_serial,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_data_next,
    output logic             o_serial
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;

    // Next register value: load wins over shift, otherwise hold.
    always_comb begin
        // NOTE: default first, so every path assigns w_data_next and no latch is inferred.
        w_data_next = r_data;
        if (i_load) begin
            w_data_next = i_data;
        end else if (i_shift) begin
            if (i_mode == MODE_LSB_FIRST) begin
                w_data_next = {i_serial, r_data[WIDTH-1:1]};
            end else begin
                w_data_next = {r_data[WIDTH-2:0], i_serial};
            end
        end
    end

    // Data register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking, so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            r_data <= '0;
        end else begin
            r_data <= w_data_next;
        end
    end

    assign o_data      = r_data;
    assign o_data_next = w_data_next;
    assign o_serial    = (i_mode == MODE_LSB_FIRST) ? r_data[0] : r_data[WIDTH-1];

endmodule

// File: rtl/shift_framer.sv
// shift_framer: serial shift register with frame counting, direction latch,
// completed-frame capture and valid/overflow handshake flags.
module shift_framer
    import shift_framer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    input  logic             lsbFirst,
    input  logic             frameAck,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic [CNT_W-1:0] bitCount,
    output logic             frameDone,
    output logic [WIDTH-1:0] frameData,
    output logic             frameValid,
    output logic             overflow
);

    logic [CNT_W-1:0] r_bit_count;
    logic             r_mode;
    logic             r_frame_done;
    logic [WIDTH-1:0] r_frame_data;
    logic             r_frame_valid;
    logic             r_overflow;

    logic             w_accept;
    logic             w_last_bit;
    logic             w_complete;
    logic [WIDTH-1:0] w_data_next;

    // A load in the same cycle swallows the shift edge entirely.
    assign w_accept   = peripheralClkEdge & ~parallelLoad;
    assign w_last_bit = (r_bit_count == CNT_W'(WIDTH - 1));
    assign w_complete = w_accept & w_last_bit;

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .i_load      (parallelLoad),
        .i_data      (parallelDataIn),
        .i_shift     (w_accept),
        .i_serial    (serialDataIn),
        .i_mode      (r_mode),
        .o_data      (parallelDataOut),
        .o_data_next (w_data_next),
        .o_serial    (serialDataOut)
    );

    // Bit counter: cleared by load, advanced by accepted edges, wraps on the frame's last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_count <= '0;
        end else if (parallelLoad) begin
            r_bit_count <= '0;
        end else if (w_accept) begin
            r_bit_count <= w_last_bit ? '0 : r_bit_count + 1'b1;
        end
    end

    // Direction only follows lsbFirst between frames, so a mid-frame change waits for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= MODE_MSB_FIRST;
        end else if (r_bit_count == '0) begin
            r_mode <= lsbFirst;
        end
    end

    // Frame capture and valid/overflow handshake; completion takes precedence over a plain ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_done  <= 1'b0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_done <= w_complete;
            if (w_complete) begin
                r_frame_data  <= w_data_next;
                r_frame_valid <= 1'b1;
                if (r_frame_valid && !frameAck) begin
                    r_overflow <= 1'b1;
                end else if (frameAck) begin
                    r_overflow <= 1'b0;
                end
            end else if (frameAck && r_frame_valid) begin
                r_frame_valid <= 1'b0;
                r_overflow    <= 1'b0;
            end
        end
    end

    assign bitCount   = r_bit_count;
    assign frameDone  = r_frame_done;
    assign frameData  = r_frame_data;
    assign frameValid = r_frame_valid;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_shift_framer.sv
// Self-checking bench for shift_framer: directed scenarios plus randomized traffic,
// compared against a behavioural model through per-cycle and per-frame scoreboards.
module tb_shift_framer;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W);
    localparam int unsigned MASK = (1 << W) - 1;

    typedef struct {
        int unsigned pdo;
        int unsigned sdo;
        int unsigned cnt;
        int unsigned fdone;
        int unsigned fdata;
        int unsigned fvalid;
        int unsigned ovf;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             peripheralClkEdge;
    logic             parallelLoad;
    logic [W-1:0]     parallelDataIn;
    logic             serialDataIn;
    logic             lsbFirst;
    logic             frameAck;
    logic [W-1:0]     parallelDataOut;
    logic             serialDataOut;
    logic [CNT_W-1:0] bitCount;
    logic             frameDone;
    logic [W-1:0]     frameData;
    logic             frameValid;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        state_q[$];
    int unsigned frame_q[$];

    // Behavioural model state
    int unsigned m_reg, m_cnt, m_mode, m_fdata, m_fvalid, m_fdone, m_ovf;

    shift_framer #(
        .WIDTH (W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .peripheralClkEdge (peripheralClkEdge),
        .parallelLoad      (parallelLoad),
        .parallelDataIn    (parallelDataIn),
        .serialDataIn      (serialDataIn),
        .lsbFirst          (lsbFirst),
        .frameAck          (frameAck),
        .parallelDataOut   (parallelDataOut),
        .serialDataOut     (serialDataOut),
        .bitCount          (bitCount),
        .frameDone         (frameDone),
        .frameData         (frameData),
        .frameValid        (frameValid),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the reference model, applied with the inputs that were presented at this edge.
    task automatic model_step(input bit rst, ld, input int unsigned din, input bit edg, sin, lsb, ack);
        bit at_frame_start;
        bit complete;
        if (rst) begin
            m_reg = 0; m_cnt = 0; m_mode = 0;
            m_fdata = 0; m_fvalid = 0; m_fdone = 0; m_ovf = 0;
            return;
        end
        at_frame_start = (m_cnt == 0);
        complete = 1'b0;
        if (ld) begin
            m_reg = din & MASK;
            m_cnt = 0;
        end else if (edg) begin
            if (m_mode != 0) m_reg = (m_reg >> 1) | (int'(sin) << (W - 1));
            else             m_reg = ((m_reg << 1) | int'(sin)) & MASK;
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
                m_cnt = 0;
                complete = 1'b1;
            end
        end
        if (at_frame_start) m_mode = lsb;
        m_fdone = complete;
        if (complete) begin
            m_fdata = m_reg;
            if (m_fvalid != 0 && !ack) m_ovf = 1;
            else if (ack)              m_ovf = 0;
            m_fvalid = 1;
            frame_q.push_back(m_reg);
        end else if (ack && m_fvalid != 0) begin
            m_fvalid = 0;
            m_ovf = 0;
        end
    endtask

    // Present inputs for one cycle, advance the model on the edge, queue the expected outputs.
    task automatic drive(input bit rst, ld, input logic [W-1:0] din, input bit edg, sin, lsb, ack);
        exp_t e;
        reset             = rst;
        parallelLoad      = ld;
        parallelDataIn    = din;
        peripheralClkEdge = edg;
        serialDataIn      = sin;
        lsbFirst          = lsb;
        frameAck          = ack;
        @(posedge clk);
        model_step(rst, ld, din, edg, sin, lsb, ack);
        e.pdo    = m_reg;
        e.sdo    = (m_mode != 0) ? (m_reg & 1) : ((m_reg >> (W - 1)) & 1);
        e.cnt    = m_cnt;
        e.fdone  = m_fdone;
        e.fdata  = m_fdata;
        e.fvalid = m_fvalid;
        e.ovf    = m_ovf;
        state_q.push_back(e);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] value, input bit lsb, input bit ack_last);
        for (int i = 0; i < W; i++) begin
            drive(0, 0, '0, 1, lsb ? value[i] : value[W-1-i], lsb, ack_last && (i == W - 1));
        end
    endtask

    // Monitor: every cycle compare the DUT against the queued expectation; on frameDone check the frame.
    always @(negedge clk) begin
        exp_t e;
        if (state_q.size() > 0) begin
            e = state_q.pop_front();
            check("parallelDataOut", 32'(parallelDataOut), e.pdo);
            check("serialDataOut",   32'(serialDataOut),   e.sdo);
            check("bitCount",        32'(bitCount),        e.cnt);
            check("frameDone",       32'(frameDone),       e.fdone);
            check("frameData",       32'(frameData),       e.fdata);
            check("frameValid",      32'(frameValid),      e.fvalid);
            check("overflow",        32'(overflow),        e.ovf);
        end
        if (frameDone === 1'b1) begin
            if (frame_q.size() == 0) begin
                check("unexpected_frame", 32'(frameData), 32'hFFFF_FFFF);
            end else begin
                check("frame_scoreboard", 32'(frameData), frame_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, n_checks=%0d expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ld, edg, lsb, rst;
        reset = 1'b1; parallelLoad = 1'b0; parallelDataIn = '0; peripheralClkEdge = 1'b0;
        serialDataIn = 1'b0; lsbFirst = 1'b0; frameAck = 1'b0;

        // Reset, then load 0xA5 MSB-first
        drive(1, 0, '0, 0, 0, 0, 0);
        drive(1, 0, '0, 0, 0, 0, 0);
        check("rst_frameValid", 32'(frameValid), 0);
        check("rst_bitCount", 32'(bitCount), 0);
        drive(0, 1, 8'hA5, 0, 0, 0, 0);
        check("load_pdo", 32'(parallelDataOut), 32'hA5);
        check("load_sdo", 32'(serialDataOut), 1);
        check("load_cnt", 32'(bitCount), 0);
        check("load_fvalid", 32'(frameValid), 0);

        // MSB-first frame 1,0,1,0,0,0,0,1 from 0x00
        drive(0, 1, 8'h00, 0, 0, 0, 0);
        send_frame(8'hA1, 0, 0);
        check("msb_fdone", 32'(frameDone), 1);
        check("msb_fdata", 32'(frameData), 32'hA1);
        check("msb_fvalid", 32'(frameValid), 1);
        check("msb_cnt", 32'(bitCount), 0);
        drive(0, 0, '0, 0, 0, 0, 0);
        check("msb_fdone_pulse", 32'(frameDone), 0);
        drive(0, 0, '0, 0, 0, 0, 1);
        check("ack_clears_valid", 32'(frameValid), 0);

        // LSB-first: load 0x01 with lsbFirst=1, shift 1,1,0.. toggling lsbFirst at bitCount 4
        drive(0, 1, 8'h01, 0, 0, 1, 0);
        check("lsb_sdo", 32'(serialDataOut), 1);
        for (int i = 0; i < W; i++) begin
            drive(0, 0, '0, 1, (i < 2) ? 1'b1 : 1'b0, (i < 4) ? 1'b1 : 1'b0, 0);
        end
        check("lsb_fdata", 32'(frameData), 32'h03);
        drive(0, 0, '0, 0, 0, 0, 1);

        // Load coincident with an edge at bitCount 3
        drive(0, 1, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, '0, 1, 1, 0, 0);
        check("pre_load_cnt", 32'(bitCount), 3);
        drive(0, 1, 8'hFF, 1, 0, 0, 0);
        check("ld_edge_pdo", 32'(parallelDataOut), 32'hFF);
        check("ld_edge_cnt", 32'(bitCount), 0);
        check("ld_edge_fdone", 32'(frameDone), 0);

        // Overflow and ack handling
        send_frame(8'h11, 0, 0);
        send_frame(8'h22, 0, 0);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_fdata", 32'(frameData), 32'h22);
        drive(0, 0, '0, 0, 0, 0, 1);
        check("ack_fvalid", 32'(frameValid), 0);
        check("ack_ovf", 32'(overflow), 0);
        send_frame(8'h33, 0, 0);
        send_frame(8'h44, 0, 1);
        check("ackcomp_fvalid", 32'(frameValid), 1);
        check("ackcomp_ovf", 32'(overflow), 0);
        check("ackcomp_fdata", 32'(frameData), 32'h44);

        // Reset mid-frame at bitCount 5
        drive(0, 0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, '0, 1, 1, 0, 0);
        drive(1, 0, '0, 0, 0, 0, 0);
        check("midrst_pdo", 32'(parallelDataOut), 0);
        check("midrst_sdo", 32'(serialDataOut), 0);
        check("midrst_cnt", 32'(bitCount), 0);
        check("midrst_fdata", 32'(frameData), 0);
        check("midrst_fvalid", 32'(frameValid), 0);
        check("midrst_ovf", 32'(overflow), 0);
        for (int i = 0; i < W - 1; i++) begin
            drive(0, 0, '0, 1, 1, 0, 0);
            check("midrst_no_fdone", 32'(frameDone), 0);
        end
        drive(0, 0, '0, 1, 1, 0, 0);
        check("midrst_fdone", 32'(frameDone), 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            edg = $urandom_range(0, 1);
            lsb = $urandom_range(0, 1);
            // Keep the first edge of a frame on the already-latched direction.
            if (!ld && edg && m_cnt == 0) lsb = m_mode[0];
            drive(rst, ld, W'($urandom), edg, $urandom_range(0, 1), lsb,
                  $urandom_range(0, 7) == 0);
        end

        drive(0, 0, '0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("state_q_drained", 32'(state_q.size()), 0);
        check("frame_q_drained", 32'(frame_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
